// File: rtl/word_packer_unit_pkg.sv
// Shared types and defaults for the byte-to-word packing path.
// Contents: default byte/word geometry, byte_t/word_t and a lane insertion helper.
package word_pack_pkg;

    localparam int unsigned BYTE_W_DEF         = 8;
    localparam int unsigned BYTES_PER_WORD_DEF = 4;

    typedef logic [BYTE_W_DEF-1:0]                    byte_t;
    typedef logic [BYTES_PER_WORD_DEF*BYTE_W_DEF-1:0] word_t;

    // Replace byte lane idx of w with b; lane 0 is the least-significant byte.
    function automatic word_t lane_insert(word_t w, byte_t b, int idx);
        word_t r;
        r = w;
        r[idx*BYTE_W_DEF +: BYTE_W_DEF] = b;
        return r;
    endfunction

endpackage

// File: rtl/word_packer_unit_if.sv
// Byte-in / word-out handshake bundle for word_packer_unit.
// master: the environment (drives in_data/in_valid/out_ready[/flush]).
// slave : the packer (drives in_ready/out_data/out_valid/out_count).
// flush only exists when WORD_PACKER_FLUSH_EN is defined.
interface word_packer_unit_if #(
    parameter int unsigned BYTES_PER_WORD = word_pack_pkg::BYTES_PER_WORD_DEF,
    parameter int unsigned BYTE_W         = word_pack_pkg::BYTE_W_DEF
);
    localparam int unsigned WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);

    logic [BYTE_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_count;
`ifdef WORD_PACKER_FLUSH_EN
    logic              flush;

    modport master (output in_data, in_valid, out_ready, flush,
                    input  in_ready, out_data, out_valid, out_count);
    modport slave  (input  in_data, in_valid, out_ready, flush,
                    output in_ready, out_data, out_valid, out_count);
`else
    modport master (output in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, out_count);
    modport slave  (input  in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, out_count);
`endif

endinterface

// File: rtl/word_out_reg.sv
// Output holding register with valid/ready; shared by packing/unpacking units.
// Ports: load/load_data/load_count capture a word; out_* present it until
// out_ready; ld_ok_c is high when a load this cycle will not overwrite a
// word still waiting downstream.
module word_out_reg #(
    parameter int unsigned WORD_W = word_pack_pkg::BYTES_PER_WORD_DEF * word_pack_pkg::BYTE_W_DEF,
    parameter int unsigned CNT_W  = $clog2(word_pack_pkg::BYTES_PER_WORD_DEF + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  logic [CNT_W-1:0]  load_count,
    output logic [WORD_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ld_ok_c
);

    assign ld_ok_c = !out_valid || out_ready;

    // A load wins over a consume so back-to-back words leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_count <= load_count;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/word_packer_unit.sv
// Packs BYTE_W-bit bytes into WORD_W-bit words, byte 0 in the least-significant
// lane. The accumulator keeps filling lower lanes while the previous word waits
// in word_out_reg; only the completing byte stalls.
// Ports: clk, rst_n (async, active-low), bus (word_packer_unit_if.slave).
// Optional: WORD_PACKER_FLUSH_EN adds bus.flush to emit a partial word.
module word_packer_unit
    import word_pack_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
    parameter int unsigned BYTE_W         = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    word_packer_unit_if.slave bus
);

    localparam int unsigned WORD_W = BYTES_PER_WORD * BYTE_W;
    localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned IDX_W  = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTES_PER_WORD);

    logic [WORD_W-1:0] acc_q, acc_d, acc_ins_c;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              ld_ok_c;
    logic              accept_c;
    logic              load_c;
    logic [WORD_W-1:0] load_data_c;
    logic [CNT_W-1:0]  load_count_c;
`ifdef WORD_PACKER_FLUSH_EN
    logic [CNT_W-1:0]  pend_c;
`endif

    // Only the byte that would complete a word needs a free output register.
    assign bus.in_ready = !((idx_q == LAST_IDX) && !ld_ok_c);
    assign accept_c     = bus.in_valid && bus.in_ready;

    // Accumulator with this cycle's accepted byte merged into lane idx.
    always_comb begin
        acc_ins_c = acc_q;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            if (accept_c && (idx_q == IDX_W'(i))) begin
                acc_ins_c[i*BYTE_W +: BYTE_W] = bus.in_data;
            end
        end
    end

    // Next-state for accumulator/index and the output-register load request.
    always_comb begin
        acc_d        = acc_q;
        idx_d        = idx_q;
        load_c       = 1'b0;
        load_data_c  = acc_ins_c;
        load_count_c = FULL_CNT;
`ifdef WORD_PACKER_FLUSH_EN
        pend_c       = CNT_W'(idx_q) + CNT_W'(accept_c);
`endif

        if (accept_c) begin
            if (idx_q == LAST_IDX) begin
                load_c = 1'b1;
                acc_d  = '0;
                idx_d  = '0;
            end else begin
                acc_d  = acc_ins_c;
                idx_d  = idx_q + IDX_W'(1);
            end
        end

`ifdef WORD_PACKER_FLUSH_EN
        // Upper lanes are already zero because the accumulator clears on emit.
        if (bus.flush && ld_ok_c && (pend_c != '0)) begin
            load_c       = 1'b1;
            load_count_c = pend_c;
            acc_d        = '0;
            idx_d        = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
        end else begin
            acc_q <= acc_d;
            idx_q <= idx_d;
        end
    end

    word_out_reg #(
        .WORD_W (WORD_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .load_data  (load_data_c),
        .load_count (load_count_c),
        .out_data   (bus.out_data),
        .out_count  (bus.out_count),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .ld_ok_c    (ld_ok_c)
    );

endmodule

// File: tb/tb_word_packer_unit.sv
// Self-checking bench for word_packer_unit (default 4 x 8-bit geometry).
module tb_word_packer_unit;

    localparam int unsigned BPW = 4;
    localparam int unsigned BW  = 8;

    logic clk;
    logic rst_n;

    word_packer_unit_if #(.BYTES_PER_WORD(BPW), .BYTE_W(BW)) bus ();

    word_packer_unit #(.BYTES_PER_WORD(BPW), .BYTE_W(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes pending in the current word plus the word presented downstream.
    logic [7:0]  pend[$];
    logic        m_valid = 1'b0;
    logic [63:0] m_word  = '0;
    int          m_count = 0;

    logic        last_acc = 1'b0;
    int          stall_cycles = 0;
    int          words_seen = 0;
    logic [63:0] got_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input int n);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = w | (64'(pend[i]) << (8 * i));
        m_word  = w;
        m_count = n;
        m_valid = 1'b1;
        pend.delete();
    endtask

    // One clock: compare DUT with model, advance model, step past the edge.
    task automatic cycle();
        logic ld_ok, exp_rdy, acc, cons;
        #1;
        ld_ok   = !m_valid || bus.out_ready;
        exp_rdy = !((pend.size() == BPW - 1) && !ld_ok);
        chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
        if (m_valid) begin
            chk("out_data", 64'(bus.out_data), m_word);
            chk("out_count", 64'(bus.out_count), 64'(m_count));
        end
        acc  = bus.in_valid && exp_rdy;
        cons = m_valid && bus.out_ready;
        if (bus.in_valid && !exp_rdy) stall_cycles++;
        if (acc) pend.push_back(bus.in_data);
        if (cons) begin
            words_seen++;
            got_q.push_back(64'(bus.out_data));
            m_valid = 1'b0;
        end
        if (pend.size() == BPW) model_load(BPW);
`ifdef WORD_PACKER_FLUSH_EN
        else if (bus.flush && ld_ok && pend.size() > 0) model_load(pend.size());
`endif
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    // Hold in_valid with byte b until it is accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 50);
        chk("accept_byte", 64'(last_acc), 64'(1));
    endtask

    function automatic logic [63:0] pack4(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [7:0] b3);
        return 64'(b0) + (64'(b1) << 8) + (64'(b2) << 16) + (64'(b3) << 24);
    endfunction

    logic [7:0]  sb[8];
    logic [7:0]  rb[64];
    logic [31:0] src;
    logic [7:0]  red;
    int          base_words, base_stall;

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
`ifdef WORD_PACKER_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_data",  64'(bus.out_data),  64'(0));
        chk("rst_out_count", 64'(bus.out_count), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();

        // Back-to-back 0x11..0x44: word visible right after the last byte, for one cycle.
        bus.out_ready = 1'b1;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        bus.in_valid = 1'b0;
        chk("t1_valid", 64'(bus.out_valid), 64'(1));
        chk("t1_data",  64'(bus.out_data),  64'h44332211);
        chk("t1_count", 64'(bus.out_count), 64'(4));
        cycle();
        chk("t1_one_cycle", 64'(bus.out_valid), 64'(0));

        // Reduce 0xDEADBEEF to its low byte, then re-pack its bytes.
        src = 32'hDEADBEEF;
        red = src[7:0];
        for (int i = 0; i < 4; i++) send_byte(8'(src >> (8 * i)));
        bus.in_valid = 1'b0;
        cycle();
        chk("deadbeef_word", got_q[got_q.size()-1], 64'hDEADBEEF);
        chk("deadbeef_low",  64'(got_q[got_q.size()-1][7:0]), 64'(red));

        // Backpressure: first word held, bytes 5-7 accepted, byte 8 stalls, no gap after release.
        for (int i = 0; i < 8; i++) sb[i] = 8'($urandom);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(sb[i]);
        bus.in_data = sb[7];
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("stall_byte8", 64'(last_acc), 64'(0));
            chk("stall_hold",  64'(bus.out_data), pack4(sb[0], sb[1], sb[2], sb[3]));
        end
        bus.out_ready = 1'b1;
        cycle();
        chk("stall_release", 64'(last_acc), 64'(1));
        bus.in_valid = 1'b0;
        chk("no_gap_valid", 64'(bus.out_valid), 64'(1));
        chk("no_gap_data",  64'(bus.out_data), pack4(sb[4], sb[5], sb[6], sb[7]));
        cycle();

        // Continuous streaming of 64 random bytes.
        got_q.delete();
        base_words = words_seen;
        base_stall = stall_cycles;
        for (int i = 0; i < 64; i++) rb[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) send_byte(rb[i]);
        bus.in_valid = 1'b0;
        cycle(); cycle();
        chk("stream_words", 64'(words_seen - base_words), 64'(16));
        chk("stream_no_stall", 64'(stall_cycles - base_stall), 64'(0));
        for (int w = 0; w < 16; w++) begin
            if (w < got_q.size())
                chk("stream_order", got_q[w], pack4(rb[4*w], rb[4*w+1], rb[4*w+2], rb[4*w+3]));
        end

        // Random valid/ready traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if (!bus.in_valid || last_acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = 8'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
`ifdef WORD_PACKER_FLUSH_EN
            bus.flush = ($urandom_range(0, 15) == 0);
`endif
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
`ifdef WORD_PACKER_FLUSH_EN
        bus.flush     = 1'b0;
`endif
        cycle();

        // Reset after two bytes: outputs clear at once, partial word is discarded.
        send_byte(8'h01); send_byte(8'h02);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_data",  64'(bus.out_data),  64'(0));
        chk("mid_rst_count", 64'(bus.out_count), 64'(0));
        pend.delete();
        m_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle();
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
        bus.in_valid = 1'b0;
        chk("post_rst_data", 64'(bus.out_data), 64'hA3A2A1A0);
        cycle();

`ifdef WORD_PACKER_FLUSH_EN
        // Partial flush after two bytes, then flush with nothing pending.
        send_byte(8'h55); send_byte(8'h66);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        cycle();
        chk("flush_valid", 64'(bus.out_valid), 64'(1));
        chk("flush_data",  64'(bus.out_data),  64'h00006655);
        chk("flush_count", 64'(bus.out_count), 64'(2));
        bus.flush = 1'b0;
        cycle();
        bus.flush = 1'b1;
        cycle();
        chk("flush_empty", 64'(bus.out_valid), 64'(0));
        bus.flush = 1'b0;
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
